// File: rtl/tank_palette_pkg.sv
// Shared types and constants for the tank sprite palette controller.
// DEFAULT_PALETTE is the power-up palette loaded into both banks.
package tank_palette_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } color_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COPY    = 2'd2
    } pal_state_t;

    localparam int PAL_DEPTH = 16;

    localparam color_t DEFAULT_PALETTE [PAL_DEPTH] = '{
        12'hB25, 12'hC94, 12'h851, 12'hFCB,
        12'h000, 12'h0F8, 12'h3A3, 12'h2C6,
        12'h8E9, 12'hFD2, 12'hE53, 12'h47F,
        12'h9BF, 12'h777, 12'hA4C, 12'hFFF
    };

    // Deeper palettes repeat the default table.
    function automatic color_t default_color(input int i);
        return DEFAULT_PALETTE[4'(i % PAL_DEPTH)];
    endfunction

endpackage

// File: rtl/palette_bank.sv
// NUM_ENTRIES x 12-bit palette register file: one write port, one
// combinational read port, reset loads the default palette.
module palette_bank
    import tank_palette_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int IDX_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [11:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [11:0]      rdata
);

    color_t mem [NUM_ENTRIES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                mem[i] <= default_color(i);
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tank_palette_ctrl.sv
// Double-buffered sprite palette: game logic writes the shadow bank, a commit
// copies it to the active bank during vblank; also applies the hit-flash.
//   state   | meaning
//   IDLE    | shadow writable, no commit outstanding
//   PENDING | commit accepted, shadow frozen, waiting for vsync_start
//   COPY    | one entry per cycle shadow -> active, pointer 0..NUM_ENTRIES-1
module tank_palette_ctrl
    import tank_palette_pkg::*;
#(
    parameter int NUM_ENTRIES  = 16,
    parameter int IDX_W        = 4,
    parameter int FLASH_FRAMES = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             vsync_start,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [11:0]      wr_color,
    input  logic             commit_req,
    output logic             commit_pending,
    input  logic             flash_trigger,
    output logic             flash_active,
    input  logic [IDX_W-1:0] pix_index,
    output logic [3:0]       red,
    output logic [3:0]       green,
    output logic [3:0]       blue
);

    pal_state_t       state_q, state_d;
    logic [IDX_W-1:0] copy_ptr;
    logic [7:0]       flash_cnt;
    logic             shadow_we, active_we;
    logic [11:0]      shadow_rd, active_rd;
    color_t           pix_q;

    palette_bank #(.NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W)) u_shadow (
        .clk   (Clk),
        .rst   (Reset),
        .we    (shadow_we),
        .waddr (wr_index),
        .wdata (wr_color),
        .raddr (copy_ptr),
        .rdata (shadow_rd)
    );

    palette_bank #(.NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W)) u_active (
        .clk   (Clk),
        .rst   (Reset),
        .we    (active_we),
        .waddr (copy_ptr),
        .wdata (shadow_rd),
        .raddr (pix_index),
        .rdata (active_rd)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (commit_req)  state_d = PENDING;
            PENDING: if (vsync_start) state_d = COPY;
            COPY:    if (copy_ptr == IDX_W'(NUM_ENTRIES - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ready       = (state_q == IDLE);
        commit_pending = (state_q != IDLE);
        shadow_we      = (state_q == IDLE) && wr_valid;
        active_we      = (state_q == COPY);
    end

    // Pointer parks at 0 while PENDING so COPY always starts at entry 0.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                  copy_ptr <= '0;
        else if (state_q == COPY)   copy_ptr <= copy_ptr + 1'b1;
        else                        copy_ptr <= '0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                              flash_cnt <= '0;
        else if (flash_trigger)                 flash_cnt <= 8'(FLASH_FRAMES);
        else if (vsync_start && flash_cnt != 0) flash_cnt <= flash_cnt - 8'd1;
    end

    assign flash_active = (flash_cnt != 0);

    // 4'hF - c per channel is a bitwise inversion of the whole colour.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)             pix_q <= '0;
        else if (flash_active) pix_q <= ~active_rd;
        else                   pix_q <= active_rd;
    end

    assign red   = pix_q.r;
    assign green = pix_q.g;
    assign blue  = pix_q.b;

endmodule

// File: tb/tb_tank_palette_ctrl.sv
// Directed bench for tank_palette_ctrl with a pixel scoreboard queue.
module tb_tank_palette_ctrl;
    import tank_palette_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       vsync_start, wr_valid, wr_ready, commit_req, commit_pending;
    logic       flash_trigger, flash_active;
    logic [3:0] wr_index, pix_index;
    logic [11:0] wr_color;
    logic [3:0] red, green, blue;

    int tests = 0;
    int fails = 0;
    logic [11:0] exp_q [$];
    logic [11:0] mdl_active [16];
    logic [11:0] mdl_shadow [16];

    always #5 clk = ~clk;

    tank_palette_ctrl #(.NUM_ENTRIES(16), .IDX_W(4), .FLASH_FRAMES(3)) dut (
        .Clk            (clk),
        .Reset          (rst),
        .vsync_start    (vsync_start),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_index       (wr_index),
        .wr_color       (wr_color),
        .commit_req     (commit_req),
        .commit_pending (commit_pending),
        .flash_trigger  (flash_trigger),
        .flash_active   (flash_active),
        .pix_index      (pix_index),
        .red            (red),
        .green          (green),
        .blue           (blue)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_px(input string tag, input logic [11:0] exp);
        tests++;
        assert ({red, green, blue} === exp) else begin
            fails++;
            $error("FAIL %s observed=%03h expected=%03h", tag, {red, green, blue}, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs == exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Push the expected colour when the index is driven, pop after the edge.
    task automatic read_px(input string tag, input logic [3:0] idx, input logic [11:0] exp);
        logic [11:0] e;
        pix_index = idx;
        exp_q.push_back(exp);
        tick();
        e = exp_q.pop_front();
        check_px(tag, e);
    endtask

    task automatic do_write(input logic [3:0] idx, input logic [11:0] c);
        wr_valid = 1'b1; wr_index = idx; wr_color = c;
        tick();
        wr_valid = 1'b0;
        mdl_shadow[idx] = c;
    endtask

    task automatic pulse_commit();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
    endtask

    task automatic pulse_vsync();
        vsync_start = 1'b1;
        tick();
        vsync_start = 1'b0;
    endtask

    task automatic wait_commit(output int n);
        n = 0;
        while (commit_pending && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mdl_active[i] = DEFAULT_PALETTE[4'(i)];
            mdl_shadow[i] = DEFAULT_PALETTE[4'(i)];
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; vsync_start = 1'b0; wr_valid = 1'b0; wr_index = '0;
        wr_color = '0; commit_req = 1'b0; flash_trigger = 1'b0; pix_index = '0;
        model_reset();
        tick(); tick();
        check_px("reset_rgb", 12'h000);
        check_bit("reset_wr_ready", wr_ready, 1'b1);
        check_bit("reset_pending", commit_pending, 1'b0);
        check_bit("reset_flash", flash_active, 1'b0);
        rst = 1'b0;

        read_px("default_idx0", 4'd0, 12'hB25);
        read_px("default_idx3", 4'd3, 12'hFCB);
        read_px("default_idx1", 4'd1, 12'hC94);

        // Write then commit; write attempts while PENDING are refused.
        do_write(4'd2, 12'h0F0);
        read_px("write_not_visible", 4'd2, 12'h851);
        pulse_commit();
        check_bit("pending_wr_ready", wr_ready, 1'b0);
        check_bit("pending_flag", commit_pending, 1'b1);
        wr_valid = 1'b1; wr_index = 4'd7; wr_color = 12'hABC;
        tick();
        wr_valid = 1'b0;
        read_px("pending_idx2_old", 4'd2, 12'h851);
        vsync_start = 1'b1;
        tick();
        vsync_start = 1'b0;
        n = 0;
        while (commit_pending && n < 40) begin
            tick();
            n++;
            check_px("copy_latency_idx2", (n >= 4) ? 12'h0F0 : 12'h851);
        end
        check_int("commit_cycles_1", n, 16);
        for (int i = 0; i < 16; i++) mdl_active[i] = mdl_shadow[i];
        check_bit("post_commit_wr_ready", wr_ready, 1'b1);
        read_px("committed_idx2", 4'd2, 12'h0F0);
        read_px("refused_write_idx7", 4'd7, mdl_active[7]);

        // vsync in IDLE does nothing.
        pulse_vsync();
        check_bit("idle_vsync_pending", commit_pending, 1'b0);

        // Write and commit in the same cycle; a second commit while PENDING is dropped.
        wr_valid = 1'b1; wr_index = 4'd5; wr_color = 12'h123; commit_req = 1'b1;
        tick();
        wr_valid = 1'b0; commit_req = 1'b0;
        mdl_shadow[5] = 12'h123;
        check_bit("simul_pending", commit_pending, 1'b1);
        pulse_commit();
        read_px("simul_before_copy", 4'd5, DEFAULT_PALETTE[5]);
        pulse_vsync();
        wait_commit(n);
        check_int("commit_cycles_2", n, 16);
        for (int i = 0; i < 16; i++) mdl_active[i] = mdl_shadow[i];
        tick(); tick();
        check_bit("no_second_commit", commit_pending, 1'b0);
        pulse_vsync();
        check_bit("no_second_commit_vsync", commit_pending, 1'b0);
        read_px("simul_idx5", 4'd5, 12'h123);
        read_px("simul_idx2_kept", 4'd2, mdl_active[2]);

        // Flash with FLASH_FRAMES=3 on an untouched entry.
        pix_index = 4'd0;
        flash_trigger = 1'b1;
        tick();
        flash_trigger = 1'b0;
        check_bit("flash_on", flash_active, 1'b1);
        read_px("flash_px_0", 4'd0, 12'h4DA);
        pulse_vsync();
        check_bit("flash_after_v1", flash_active, 1'b1);
        read_px("flash_px_v1", 4'd0, 12'h4DA);
        pulse_vsync();
        check_bit("flash_after_v2", flash_active, 1'b1);
        read_px("flash_px_v2", 4'd0, 12'h4DA);
        pulse_vsync();
        check_bit("flash_after_v3", flash_active, 1'b0);
        read_px("flash_px_v3", 4'd0, 12'hB25);

        flash_trigger = 1'b1;
        tick();
        flash_trigger = 1'b0;
        pulse_vsync();
        pulse_vsync();
        flash_trigger = 1'b1; vsync_start = 1'b1;
        tick();
        flash_trigger = 1'b0; vsync_start = 1'b0;
        pulse_vsync();
        pulse_vsync();
        check_bit("reload_still_on", flash_active, 1'b1);
        read_px("reload_px", 4'd0, 12'h4DA);
        pulse_vsync();
        check_bit("reload_off", flash_active, 1'b0);

        // Reset in the middle of a copy.
        do_write(4'd0, 12'h111);
        do_write(4'd9, 12'h999);
        pulse_commit();
        pulse_vsync();
        for (int i = 0; i < 7; i++) tick();
        check_bit("mid_copy_pending", commit_pending, 1'b1);
        rst = 1'b1;
        #2;
        check_bit("rst_copy_pending", commit_pending, 1'b0);
        check_bit("rst_copy_wr_ready", wr_ready, 1'b1);
        check_px("rst_copy_rgb", 12'h000);
        tick();
        rst = 1'b0;
        model_reset();
        read_px("rst_copy_idx0", 4'd0, 12'hB25);
        read_px("rst_copy_idx2", 4'd2, 12'h851);
        read_px("rst_copy_idx5", 4'd5, mdl_active[5]);
        read_px("rst_copy_idx9", 4'd9, mdl_active[9]);

        // A fresh commit proves the shadow bank was reset as well.
        pulse_commit();
        pulse_vsync();
        wait_commit(n);
        check_int("commit_cycles_3", n, 16);
        read_px("shadow_reset_idx0", 4'd0, 12'hB25);
        read_px("shadow_reset_idx9", 4'd9, mdl_active[9]);
        check_int("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
